mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Controller that shares the single-ported main memory between the I-cache miss path, the D-cache miss path, and D-side write-through stores.
- Sequences 8-word block fills from a pipelined, fixed-latency main memory and writes the returned words into the owning cache's data array, then writes the tag.
- Produces i_fsm_busy / d_fsm_busy, which the hazard unit uses to stall fetch and the whole pipeline respectively.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block (16 bytes); power of two.
- MEM_LAT, 4, cycles from mem_en read issue to mem_data_valid.
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_miss  in  1  I-cache miss, held until the tag is written.
- i_miss_addr  in  16  I-side miss byte address.
- d_miss  in  1  D-cache read miss, held until the tag is written.
- d_miss_addr  in  16  D-side miss byte address.
- d_wr_req  in  1  write-through store request; held until ack.
- d_wr_addr  in  16  store byte address.
- d_wr_data  in  16  store data.
- d_wr_ack  out  1  store accepted this cycle.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  write (1) or read (0); valid only when mem_en=1.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_data_valid  in  1  mem_rdata valid, MEM_LAT cycles after a read issue.
- fill_data  out  16  word to write into the cache data array.
- fill_word  out  3  word index within the block.
- fill_we_i / fill_we_d  out  1  data-array write strobe, I-cache / D-cache.
- tag_we_i / tag_we_d  out  1  one-cycle tag/valid write strobe, I-cache / D-cache.
- fill_blk  out  12  block address (addr[15:4]) of the current fill.
- i_fsm_busy  out  1  I-side stall.
- d_fsm_busy  out  1  D-side stall.

Behaviour:
- Reset:
  - State returns to IDLE; issue_cnt = recv_cnt = 0; owner = I; latched block = 0.
  - All strobes, mem_en, and d_wr_ack are 0; mem_addr, mem_wdata, and fill_blk are 0.
- States: IDLE, FILL, TAG.
- IDLE arbitration, evaluated combinationally each cycle, priority d_wr_req > d_miss > i_miss:
  - d_wr_req: drive mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1 in the same cycle; stay in IDLE.
  - d_miss (no store): latch blk = d_miss_addr[15:4], owner = D; go to FILL.
  - i_miss (alone): latch blk = i_miss_addr[15:4], owner = I; go to FILL.
- FILL:
  - Issue: while issue_cnt < 8, drive mem_en=1, mem_wr=0, mem_addr = {blk, issue_cnt, 1'b0}, and increment issue_cnt. One read is issued per cycle, on 8 consecutive cycles.
  - Receive: on each mem_data_valid, fill_data = mem_rdata, fill_word = recv_cnt, and fill_we_<owner> = 1; increment recv_cnt.
  - After the 8th valid, go to TAG.
- TAG: tag_we_<owner> = 1 for one cycle; clear both counters; go to IDLE.
- Timing for a miss granted at cycle T:
  - Reads issue on T+1..T+8.
  - Data returns on T+5..T+12.
  - TAG at T+13; back in IDLE at T+14.
- Busy outputs (combinational):
  - i_fsm_busy = i_miss | (state≠IDLE & owner=I).
  - d_fsm_busy = d_miss | (d_wr_req & ~d_wr_ack) | (state≠IDLE & owner=D).
  - Both drop once the cache stops requesting, which happens after the tag write.
- Boundaries:
  - d_wr_req during FILL/TAG: no ack; the request is held and serviced on the first IDLE cycle.
  - A miss arriving during another owner's fill waits; there is no preemption.
  - Miss deasserted mid-fill: the fill completes and the tag is still written.
  - mem_data_valid in IDLE, or after the 8th word: ignored, no strobes.
  - fill_blk is held constant for the whole fill.
  - Counters are 4 bits; there is no wrap past 8.
  - Reset mid-fill: the tag is never written, so the partially filled block stays invalid.
  - Back-to-back misses: a new grant is possible on the first IDLE cycle after TAG.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, FILL=2'd1, TAG=2'd2.
  - Owner encoding: OWN_I=1'b0, OWN_D=1'b1.
  - Constants BLOCK_WORDS and MEM_LAT, plus OFF_W=3 and BLK_W=12.
- Sub-module fill_seq contains issue_cnt, recv_cnt, issue_done, and recv_done. It is instantiated once; the arbiter FSM wraps it.

Test Plan:
- I-miss only: i_miss=1, i_miss_addr=16'h0246 at T.
  - Reads issue to 0x0240, 0x0242, …, 0x024E on T+1..T+8.
  - Memory returns 0xA000+k; fill_we_i with fill_word=k on T+5..T+12.
  - tag_we_i on T+13; fill_blk=12'h024 throughout.
- Simultaneous d_miss (0x1000) and i_miss (0x2000):
  - D fill first; i_fsm_busy stays 1 throughout.
  - I fill is granted on the first IDLE cycle after tag_we_d; no fill_we_i until then.
- Store in IDLE: d_wr_req with addr 0x3002, data 0xBEEF.
  - Same cycle: mem_en=1, mem_wr=1, d_wr_ack=1; d_fsm_busy=0.
- Store during I fill:
  - d_wr_ack=0 and d_fsm_busy=1 until the fill finishes.
  - Ack on the first IDLE cycle; then d_fsm_busy=0.
- Reset mid-fill: rst_n low at T+7.
  - All outputs go to 0 immediately; no tag_we; state is IDLE after release.
- Stray mem_data_valid in IDLE: no fill_we or tag_we; the next fill uses word indices 0..7 correctly.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and constants for the main-memory arbiter
package mem_arbiter_pkg;

   localparam int BLOCK_WORDS = 8;
   localparam int MEM_LAT     = 4;
   localparam int OFF_W       = 3;
   localparam int BLK_W       = 12;
   localparam int CNT_W       = OFF_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      TAG  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Block address of a byte address: drops the word offset and byte-select bits.
   function automatic logic [BLK_W-1:0] blk_of(input logic [15:0] addr);
      return addr[15 -: BLK_W];
   endfunction

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// rtl/mem_arbiter_fill_seq.sv - issue/receive counters for one block fill
// Read data is accepted only when a read issued MEM_LAT cycles earlier is due.
module fill_seq
   import mem_arbiter_pkg::*;
#(
   parameter int BLOCK_WORDS = 8,
   parameter int MEM_LAT     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             issue_i,
   input  logic             valid_i,
   output logic [CNT_W-1:0] issue_cnt_o,
   output logic [CNT_W-1:0] recv_cnt_o,
   output logic             issue_done_o,
   output logic             recv_done_o,
   output logic             recv_take_o,
   output logic             recv_last_o
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

   logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
   logic [MEM_LAT-1:0] inflight_q, inflight_d;
   logic               issue_step;

   assign issue_done_o = (issue_cnt_q == CNT_FULL);
   assign recv_done_o  = (recv_cnt_q == CNT_FULL);
   assign issue_step   = issue_i & ~issue_done_o;
   assign recv_take_o  = valid_i & inflight_q[MEM_LAT-1] & ~recv_done_o;
   assign recv_last_o  = recv_take_o & (recv_cnt_q == CNT_LAST);
   assign issue_cnt_o  = issue_cnt_q;
   assign recv_cnt_o   = recv_cnt_q;

   always_comb begin
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      inflight_d  = inflight_q;
      if (clear_i) begin
         issue_cnt_d = '0;
         recv_cnt_d  = '0;
         inflight_d  = '0;
      end else begin
         if (issue_step) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
         end
         if (recv_take_o) begin
            recv_cnt_d = recv_cnt_q + CNT_W'(1);
         end
         inflight_d = (inflight_q << 1) | MEM_LAT'(issue_step);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         inflight_q  <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         inflight_q  <= inflight_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares main memory between I-fill, D-fill and D write-through stores
// Stores win in IDLE; a granted fill runs to its tag write without preemption.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int BLOCK_WORDS = 8,
   parameter int MEM_LAT     = 4,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss,
   input  logic [ADDR_W-1:0] i_miss_addr,
   input  logic              d_miss,
   input  logic [ADDR_W-1:0] d_miss_addr,
   input  logic              d_wr_req,
   input  logic [ADDR_W-1:0] d_wr_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic              d_wr_ack,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_data_valid,
   output logic [DATA_W-1:0] fill_data,
   output logic [OFF_W-1:0]  fill_word,
   output logic              fill_we_i,
   output logic              fill_we_d,
   output logic              tag_we_i,
   output logic              tag_we_d,
   output logic [BLK_W-1:0]  fill_blk,
   output logic              i_fsm_busy,
   output logic              d_fsm_busy
);

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic [BLK_W-1:0] blk_q, blk_d;

   logic             seq_clear;
   logic             seq_issue;
   logic [CNT_W-1:0] issue_cnt;
   logic [CNT_W-1:0] recv_cnt;
   logic             issue_done;
   logic             recv_done;
   logic             recv_take;
   logic             recv_last;
   logic             unused_bits;

   fill_seq #(
      .BLOCK_WORDS (BLOCK_WORDS),
      .MEM_LAT     (MEM_LAT)
   ) u_fill_seq (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (seq_clear),
      .issue_i      (seq_issue),
      .valid_i      (mem_data_valid),
      .issue_cnt_o  (issue_cnt),
      .recv_cnt_o   (recv_cnt),
      .issue_done_o (issue_done),
      .recv_done_o  (recv_done),
      .recv_take_o  (recv_take),
      .recv_last_o  (recv_last)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      blk_d     = blk_q;
      seq_clear = 1'b0;
      seq_issue = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      d_wr_ack  = 1'b0;
      fill_data = '0;
      fill_word = '0;
      fill_we_i = 1'b0;
      fill_we_d = 1'b0;
      tag_we_i  = 1'b0;
      tag_we_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (d_wr_req) begin
               mem_en    = 1'b1;
               mem_wr    = 1'b1;
               mem_addr  = d_wr_addr;
               mem_wdata = d_wr_data;
               d_wr_ack  = 1'b1;
            end else if (d_miss) begin
               blk_d   = blk_of(d_miss_addr);
               owner_d = OWN_D;
               state_d = FILL;
            end else if (i_miss) begin
               blk_d   = blk_of(i_miss_addr);
               owner_d = OWN_I;
               state_d = FILL;
            end
         end

         FILL: begin
            if (!issue_done) begin
               seq_issue = 1'b1;
               mem_en    = 1'b1;
               mem_addr  = ADDR_W'({blk_q, issue_cnt[OFF_W-1:0], 1'b0});
            end
            if (recv_take) begin
               fill_data = mem_rdata;
               fill_word = recv_cnt[OFF_W-1:0];
               fill_we_i = (owner_q == OWN_I);
               fill_we_d = (owner_q == OWN_D);
            end
            if (recv_last) begin
               state_d = TAG;
            end
         end

         TAG: begin
            tag_we_i  = (owner_q == OWN_I);
            tag_we_d  = (owner_q == OWN_D);
            seq_clear = 1'b1;
            state_d   = IDLE;
         end

         default: begin
            seq_clear = 1'b1;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= OWN_I;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         blk_q   <= blk_d;
      end
   end

   assign fill_blk   = blk_q;
   assign i_fsm_busy = i_miss | ((state_q != IDLE) & (owner_q == OWN_I));
   assign d_fsm_busy = d_miss | (d_wr_req & ~d_wr_ack)
                     | ((state_q != IDLE) & (owner_q == OWN_D));

   // Offset bits of miss addresses and counter MSBs carry no information here.
   assign unused_bits = ^{i_miss_addr[ADDR_W-BLK_W-1:0], d_miss_addr[ADDR_W-BLK_W-1:0],
                          issue_cnt[CNT_W-1], recv_cnt[CNT_W-1], recv_done};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_miss, d_miss, d_wr_req;
   logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
   logic        d_wr_ack, mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
   logic        mem_data_valid;
   logic [2:0]  fill_word;
   logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d;
   logic [11:0] fill_blk;
   logic        i_fsm_busy, d_fsm_busy;
   logic        stray_v;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_miss         (i_miss),
      .i_miss_addr    (i_miss_addr),
      .d_miss         (d_miss),
      .d_miss_addr    (d_miss_addr),
      .d_wr_req       (d_wr_req),
      .d_wr_addr      (d_wr_addr),
      .d_wr_data      (d_wr_data),
      .d_wr_ack       (d_wr_ack),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_data_valid (mem_data_valid),
      .fill_data      (fill_data),
      .fill_word      (fill_word),
      .fill_we_i      (fill_we_i),
      .fill_we_d      (fill_we_d),
      .tag_we_i       (tag_we_i),
      .tag_we_d       (tag_we_d),
      .fill_blk       (fill_blk),
      .i_fsm_busy     (i_fsm_busy),
      .d_fsm_busy     (d_fsm_busy)
   );

   // Fixed-latency memory: a read issued in cycle c returns in cycle c+4 with 0xA000 + word index.
   logic [3:0]  rd_v = 4'h0;
   logic [15:0] rd_a [4];
   always @(posedge clk) begin
      rd_v    <= {rd_v[2:0], mem_en & ~mem_wr};
      rd_a[0] <= mem_addr;
      rd_a[1] <= rd_a[0];
      rd_a[2] <= rd_a[1];
      rd_a[3] <= rd_a[2];
   end
   assign mem_data_valid = rd_v[3] | stray_v;
   assign mem_rdata      = rd_v[3] ? (16'hA000 + {13'h0, rd_a[3][3:1]}) : 16'h0;

   // Observed outputs, with fields masked where their qualifying strobe is low.
   logic [71:0] obs;
   assign obs = {mem_en, mem_en & mem_wr, mem_en ? mem_addr : 16'h0,
                 (mem_en & mem_wr) ? mem_wdata : 16'h0, d_wr_ack, fill_we_i, fill_we_d,
                 (fill_we_i | fill_we_d) ? fill_word : 3'h0,
                 (fill_we_i | fill_we_d) ? fill_data : 16'h0,
                 tag_we_i, tag_we_d, fill_blk, i_fsm_busy, d_fsm_busy};

   function automatic logic [71:0] exp_vec(input logic en, input logic wr, input logic [15:0] addr,
                                           input logic [15:0] wdata, input logic ack,
                                           input logic fwi, input logic fwd, input logic [2:0] word,
                                           input logic [15:0] data, input logic twi, input logic twd,
                                           input logic [11:0] blk, input logic ib, input logic db);
      return {en, wr, addr, wdata, ack, fwi, fwd, word, data, twi, twd, blk, ib, db};
   endfunction

   // Expected outputs k cycles after a fill grant (k >= 1).
   function automatic logic [71:0] fill_exp(input int k, input logic own, input logic [11:0] blk,
                                            input logic ib, input logic db);
      logic        en, fw, tw;
      logic [2:0]  w, ki;
      logic [15:0] addr, data;
      en   = (k >= 1) && (k <= 8);
      fw   = (k >= 5) && (k <= 12);
      tw   = (k == 13);
      ki   = 3'(k - 1);
      w    = fw ? 3'(k - 5) : 3'h0;
      addr = en ? {blk, ki, 1'b0} : 16'h0;
      data = fw ? (16'hA000 + 16'(k - 5)) : 16'h0;
      return exp_vec(en, 1'b0, addr, 16'h0, 1'b0, fw & ~own, fw & own, w, data,
                     tw & ~own, tw & own, blk, ib, db);
   endfunction

   logic [71:0] e;

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL reset_outputs got %h want %h", obs, e);
      end
      n_cmp++;
      if ({mem_addr, mem_wdata, fill_blk} !== 44'h0) begin
         n_bad++;
         $display("FAIL reset_raw got %h want 0", {mem_addr, mem_wdata, fill_blk});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (obs !== e) begin
         n_bad++;
         $display("FAIL reset_idle got %h want %h", obs, e);
      end
   endtask

   task automatic test_imiss();
      @(negedge clk);
      i_miss = 1'b1;
      i_miss_addr = 16'h0246;
      #1;
      n_cmp++;
      e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 1, 0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL imiss_grant got %h want %h", obs, e);
      end
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         e = fill_exp(k, 1'b0, 12'h024, k <= 13, 1'b0);
         if (obs !== e) begin
            n_bad++;
            $display("FAIL imiss cyc=%0d got %h want %h", k, obs, e);
         end
         if (k == 13) i_miss = 1'b0;
      end
   endtask

   task automatic test_dual();
      @(negedge clk);
      d_miss = 1'b1;
      d_miss_addr = 16'h1000;
      i_miss = 1'b1;
      i_miss_addr = 16'h2000;
      #1;
      n_cmp++;
      e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h024, 1, 1);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL dual_grant got %h want %h", obs, e);
      end
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         e = fill_exp(k, 1'b1, 12'h100, 1'b1, k <= 13);
         if (obs !== e) begin
            n_bad++;
            $display("FAIL dual_dfill cyc=%0d got %h want %h", k, obs, e);
         end
         if (k == 13) d_miss = 1'b0;
      end
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         e = fill_exp(j, 1'b0, 12'h200, j <= 13, 1'b0);
         if (obs !== e) begin
            n_bad++;
            $display("FAIL dual_ifill cyc=%0d got %h want %h", j, obs, e);
         end
         if (j == 13) i_miss = 1'b0;
      end
   endtask

   task automatic test_store_idle();
      @(negedge clk);
      d_wr_req = 1'b1;
      d_wr_addr = 16'h3002;
      d_wr_data = 16'hBEEF;
      #1;
      n_cmp++;
      e = exp_vec(1, 1, 16'h3002, 16'hBEEF, 1, 0, 0, 0, 0, 0, 0, 12'h200, 0, 0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL store_idle got %h want %h", obs, e);
      end
      @(negedge clk);
      d_wr_req = 1'b0;
      #1;
      n_cmp++;
      e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h200, 0, 0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL store_idle_after got %h want %h", obs, e);
      end
   endtask

   task automatic test_store_during_fill();
      @(negedge clk);
      i_miss = 1'b1;
      i_miss_addr = 16'h0480;
      #1;
      n_cmp++;
      e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h200, 1, 0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL stfill_grant got %h want %h", obs, e);
      end
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 2) begin
            d_wr_req = 1'b1;
            d_wr_addr = 16'h3004;
            d_wr_data = 16'h1234;
         end
         if (k == 15) d_wr_req = 1'b0;
         #1;
         if (k <= 13)
            e = fill_exp(k, 1'b0, 12'h048, 1'b1, k >= 2);
         else if (k == 14)
            e = exp_vec(1, 1, 16'h3004, 16'h1234, 1, 0, 0, 0, 0, 0, 0, 12'h048, 0, 0);
         else
            e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h048, 0, 0);
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL stfill cyc=%0d got %h want %h", k, obs, e);
         end
         if (k == 13) i_miss = 1'b0;
      end
   endtask

   task automatic test_reset_mid_fill();
      @(negedge clk);
      i_miss = 1'b1;
      i_miss_addr = 16'h0560;
      #1;
      n_cmp++;
      e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h048, 1, 0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL rstmid_grant got %h want %h", obs, e);
      end
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 7) begin
            rst_n = 1'b0;
            i_miss = 1'b0;
         end
         if (k == 9) rst_n = 1'b1;
         #1;
         if (k <= 6)
            e = fill_exp(k, 1'b0, 12'h056, 1'b1, 1'b0);
         else
            e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL rstmid cyc=%0d got %h want %h", k, obs, e);
         end
      end
   endtask

   task automatic test_stray_valid();
      e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         stray_v = 1'b1;
         #1;
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL stray_idle cyc=%0d got %h want %h", s, obs, e);
         end
      end
      @(negedge clk);
      stray_v = 1'b0;
      i_miss = 1'b1;
      i_miss_addr = 16'h0A10;
      #1;
      n_cmp++;
      e = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 1, 0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL stray_grant got %h want %h", obs, e);
      end
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         stray_v = (k >= 13);
         #1;
         n_cmp++;
         e = fill_exp(k, 1'b0, 12'h0A1, k <= 13, 1'b0);
         if (obs !== e) begin
            n_bad++;
            $display("FAIL stray_fill cyc=%0d got %h want %h", k, obs, e);
         end
         if (k == 13) i_miss = 1'b0;
      end
      @(negedge clk);
      stray_v = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      i_miss      = 1'b0;
      d_miss      = 1'b0;
      d_wr_req    = 1'b0;
      i_miss_addr = 16'h0;
      d_miss_addr = 16'h0;
      d_wr_addr   = 16'h0;
      d_wr_data   = 16'h0;
      stray_v     = 1'b0;
      test_reset();
      test_imiss();
      test_dual();
      test_store_idle();
      test_store_during_fill();
      test_reset_mid_fill();
      test_stray_valid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
